fold_step_scheduler: RTL and testbench

Sequencer for the folded spatial-encoding datapath. On each accepted feature window it issues one handshaked step per (fold, modality, channel) triple. Each step tells the HV generator / spatial encoder which fold slice, modality and channel to process, and the step stream carries boundary flags that drive fuser accumulation and clearing. Per-modality channel counts come in at runtime to support channel-count sweeps without re-synthesis.

---
 rtl/fold_step_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_fold_step_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fold_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fold_step_scheduler
//  Purpose  : Issues one handshaked (fold, modality, channel) step per cycle
//             for each accepted feature window, with fuser boundary flags.
//  Revision : 1.0  initial release
// ============================================================================
module fold_step_scheduler #(
    parameter int NUM_FOLDS             = 4,
    parameter int NUM_FOLDS_WIDTH       = 2,
    parameter int MAX_NUM_CHANNEL_WIDTH = 7
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             fin_valid,
    output logic                             fin_ready,
    input  logic [MAX_NUM_CHANNEL_WIDTH-1:0] cfg_num_channel_0,
    input  logic [MAX_NUM_CHANNEL_WIDTH-1:0] cfg_num_channel_1,
    input  logic [MAX_NUM_CHANNEL_WIDTH-1:0] cfg_num_channel_2,
    input  logic                             soft_clear,
    output logic                             step_valid,
    input  logic                             step_ready,
    output logic [NUM_FOLDS_WIDTH-1:0]       step_fold,
    output logic [1:0]                       step_modality,
    output logic [MAX_NUM_CHANNEL_WIDTH-1:0] step_channel,
    output logic                             step_first_channel,
    output logic                             step_last_channel,
    output logic                             step_last_fold,
    output logic                             done
);

    localparam logic [NUM_FOLDS_WIDTH-1:0]       c_last_fold = NUM_FOLDS_WIDTH'(NUM_FOLDS - 1);
    localparam logic [NUM_FOLDS_WIDTH-1:0]       c_fold_one  = NUM_FOLDS_WIDTH'(1);
    localparam logic [MAX_NUM_CHANNEL_WIDTH-1:0] c_ch_one    = MAX_NUM_CHANNEL_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                           r_state,    w_state_nxt;
    logic [NUM_FOLDS_WIDTH-1:0]       r_fold,     w_fold_nxt;
    logic [1:0]                       r_mod,      w_mod_nxt;
    logic [MAX_NUM_CHANNEL_WIDTH-1:0] r_ch,       w_ch_nxt;
    logic [MAX_NUM_CHANNEL_WIDTH-1:0] r_cnt0,     w_cnt0_nxt;
    logic [MAX_NUM_CHANNEL_WIDTH-1:0] r_cnt1,     w_cnt1_nxt;
    logic [MAX_NUM_CHANNEL_WIDTH-1:0] r_cnt2,     w_cnt2_nxt;
    logic                             r_alive;

    logic [MAX_NUM_CHANNEL_WIDTH-1:0] w_cur_cnt;
    logic                             w_ch_last;
    logic [2:0]                       w_nz_cfg;
    logic [2:0]                       w_nz_lat;
    logic                             w_next_found;
    logic [1:0]                       w_next_mod;
    logic                             w_accept;

    // Lowest-index modality whose count is nonzero (caller guarantees one exists).
    function automatic logic [1:0] first_nz(input logic [2:0] nz);
        if (nz[0])      return 2'd0;
        else if (nz[1]) return 2'd1;
        else            return 2'd2;
    endfunction

    assign w_nz_cfg = {cfg_num_channel_2 != '0, cfg_num_channel_1 != '0, cfg_num_channel_0 != '0};
    assign w_nz_lat = {r_cnt2 != '0, r_cnt1 != '0, r_cnt0 != '0};

    always_comb begin
        w_cur_cnt = r_cnt2;
        case (r_mod)
            2'd0:    w_cur_cnt = r_cnt0;
            2'd1:    w_cur_cnt = r_cnt1;
            default: w_cur_cnt = r_cnt2;
        endcase
    end

    assign w_ch_last = (r_ch == (w_cur_cnt - c_ch_one));

    // Next nonzero modality after the current one, within the same fold.
    always_comb begin
        w_next_found = 1'b0;
        w_next_mod   = 2'd0;
        case (r_mod)
            2'd0: begin
                if (w_nz_lat[1]) begin
                    w_next_found = 1'b1;
                    w_next_mod   = 2'd1;
                end else if (w_nz_lat[2]) begin
                    w_next_found = 1'b1;
                    w_next_mod   = 2'd2;
                end
            end
            2'd1: begin
                if (w_nz_lat[2]) begin
                    w_next_found = 1'b1;
                    w_next_mod   = 2'd2;
                end
            end
            default: begin
                w_next_found = 1'b0;
                w_next_mod   = 2'd0;
            end
        endcase
    end

    assign w_accept = fin_valid && fin_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_fold_nxt  = r_fold;
        w_mod_nxt   = r_mod;
        w_ch_nxt    = r_ch;
        w_cnt0_nxt  = r_cnt0;
        w_cnt1_nxt  = r_cnt1;
        w_cnt2_nxt  = r_cnt2;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_cnt0_nxt = cfg_num_channel_0;
                    w_cnt1_nxt = cfg_num_channel_1;
                    w_cnt2_nxt = cfg_num_channel_2;
                    w_fold_nxt = '0;
                    w_ch_nxt   = '0;
                    if (w_nz_cfg != 3'b000) begin
                        w_mod_nxt   = first_nz(w_nz_cfg);
                        w_state_nxt = S_ISSUE;
                    end else begin
                        w_mod_nxt   = 2'd0;
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_ISSUE: begin
                if (step_ready) begin
                    if (!w_ch_last) begin
                        w_ch_nxt = r_ch + c_ch_one;
                    end else if (w_next_found) begin
                        w_mod_nxt = w_next_mod;
                        w_ch_nxt  = '0;
                    end else if (r_fold != c_last_fold) begin
                        w_fold_nxt = r_fold + c_fold_one;
                        w_mod_nxt  = first_nz(w_nz_lat);
                        w_ch_nxt   = '0;
                    end else begin
                        w_fold_nxt  = '0;
                        w_mod_nxt   = 2'd0;
                        w_ch_nxt    = '0;
                        w_state_nxt = S_DONE;
                    end
                end
            end

            S_DONE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over any transition computed above.
        if (soft_clear) begin
            w_state_nxt = S_IDLE;
            w_fold_nxt  = '0;
            w_mod_nxt   = 2'd0;
            w_ch_nxt    = '0;
            w_cnt0_nxt  = '0;
            w_cnt1_nxt  = '0;
            w_cnt2_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_fold  <= '0;
            r_mod   <= 2'd0;
            r_ch    <= '0;
            r_cnt0  <= '0;
            r_cnt1  <= '0;
            r_cnt2  <= '0;
            r_alive <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fold  <= w_fold_nxt;
            r_mod   <= w_mod_nxt;
            r_ch    <= w_ch_nxt;
            r_cnt0  <= w_cnt0_nxt;
            r_cnt1  <= w_cnt1_nxt;
            r_cnt2  <= w_cnt2_nxt;
            r_alive <= 1'b1;
        end
    end

    // r_alive keeps fin_ready low during reset even though the state reads IDLE.
    assign fin_ready          = r_alive && (r_state == S_IDLE);
    assign step_valid         = (r_state == S_ISSUE);
    assign done               = (r_state == S_DONE);
    assign step_fold          = r_fold;
    assign step_modality      = r_mod;
    assign step_channel       = r_ch;
    assign step_first_channel = step_valid && (r_ch == '0);
    assign step_last_channel  = step_valid && w_ch_last;
    assign step_last_fold     = step_valid && (r_fold == c_last_fold);

endmodule
`default_nettype wire

// File: tb/tb_fold_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fold_step_scheduler
//  Purpose  : Directed self-checking bench for fold_step_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fold_step_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fin_valid = 1'b0;
    logic       fin_ready;
    logic [6:0] cfg0 = '0, cfg1 = '0, cfg2 = '0;
    logic       soft_clear = 1'b0;
    logic       step_valid;
    logic       step_ready = 1'b0;
    logic [1:0] step_fold;
    logic [1:0] step_modality;
    logic [6:0] step_channel;
    logic       step_first_channel, step_last_channel, step_last_fold;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fold_step_scheduler #(
        .NUM_FOLDS(4), .NUM_FOLDS_WIDTH(2), .MAX_NUM_CHANNEL_WIDTH(7)
    ) dut (
        .clk(clk), .rst(rst),
        .fin_valid(fin_valid), .fin_ready(fin_ready),
        .cfg_num_channel_0(cfg0), .cfg_num_channel_1(cfg1), .cfg_num_channel_2(cfg2),
        .soft_clear(soft_clear),
        .step_valid(step_valid), .step_ready(step_ready),
        .step_fold(step_fold), .step_modality(step_modality), .step_channel(step_channel),
        .step_first_channel(step_first_channel), .step_last_channel(step_last_channel),
        .step_last_fold(step_last_fold), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_word();
        return {18'd0, step_last_fold, step_last_channel, step_first_channel,
                step_fold, step_modality, step_channel};
    endfunction

    // abort_kind: 0 none, 1 async reset, 2 soft_clear; abort_at = handshakes done before abort
    task automatic run_win(input int c0, input int c1, input int c2, input bit rnd,
                           input int abort_kind, input int abort_at, input bit chg);
        logic [31:0] exp_q[$];
        int cnt[3];
        int total, j, idx;
        bit fin, prev_stall;
        logic [31:0] prev, obs;

        cnt[0] = c0; cnt[1] = c1; cnt[2] = c2;
        for (int f = 0; f < 4; f++)
            for (int m = 0; m < 3; m++)
                for (int c = 0; c < cnt[m]; c++)
                    exp_q.push_back(32'((((f == 3) ? 1 : 0) << 13) |
                                        (((c == cnt[m] - 1) ? 1 : 0) << 12) |
                                        (((c == 0) ? 1 : 0) << 11) |
                                        (f << 9) | (m << 7) | c));
        total = exp_q.size();

        @(negedge clk);
        chk("fin_ready_idle", 32'(fin_ready), 32'd1);
        chk("idle_no_valid", 32'(step_valid), 32'd0);
        cfg0 = 7'(c0); cfg1 = 7'(c1); cfg2 = 7'(c2);
        fin_valid  = 1'b1;
        step_ready = 1'b1;

        j = 0; idx = 0; fin = 1'b0; prev_stall = 1'b0; prev = '0;
        while (!fin) begin
            @(negedge clk);
            j++;
            if (j == 1) begin
                fin_valid = 1'b0;
                if (chg) begin cfg0 = 7'd7; cfg1 = 7'd7; cfg2 = 7'd7; end
            end
            if (j > 4000) begin
                n_cmp++; n_err++;
                $error("FAIL timeout observed=%0d handshakes expected=%0d", idx, total);
                return;
            end
            obs = obs_word();
            if (abort_kind != 0 && step_valid && idx == abort_at) begin
                if (abort_kind == 1) begin
                    rst = 1'b0;
                    #1;
                    chk("rst_valid_drop", 32'(step_valid), 32'd0);
                    chk("rst_no_done", 32'(done), 32'd0);
                    chk("rst_fin_ready", 32'(fin_ready), 32'd0);
                    chk("rst_fields_zero", obs_word(), 32'd0);
                    @(negedge clk);
                    chk("rst_hold_valid", 32'(step_valid), 32'd0);
                    rst = 1'b1;
                    @(negedge clk);
                    chk("rst_release_ready", 32'(fin_ready), 32'd1);
                    chk("rst_release_done", 32'(done), 32'd0);
                end else begin
                    soft_clear = 1'b1;
                    @(negedge clk);
                    soft_clear = 1'b0;
                    chk("sc_valid_drop", 32'(step_valid), 32'd0);
                    chk("sc_no_done", 32'(done), 32'd0);
                    chk("sc_fin_ready", 32'(fin_ready), 32'd1);
                    @(negedge clk);
                    chk("sc_still_no_done", 32'(done), 32'd0);
                end
                return;
            end
            if (prev_stall) begin
                chk("stall_valid", 32'(step_valid), 32'd1);
                chk("stall_hold", obs, prev);
            end
            step_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (step_valid) begin
                if (idx < total) chk("step", obs, exp_q[idx]);
                else             chk("extra_step", 32'(idx), 32'(total));
                prev_stall = !step_ready;
                prev       = obs;
                if (step_ready) idx++;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) begin
                chk("handshakes", 32'(idx), 32'(total));
                if (!rnd) chk("done_cycle", 32'(j), 32'(total + 1));
                fin = 1'b1;
            end
        end
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("fin_ready_back", 32'(fin_ready), 32'd1);
        chk("post_no_valid", 32'(step_valid), 32'd0);
    endtask

    initial begin
        #2;
        chk("rst_fin_ready", 32'(fin_ready), 32'd0);
        chk("rst_step_valid", 32'(step_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fields", obs_word(), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rel_fin_ready", 32'(fin_ready), 32'd1);

        run_win(2, 3, 1, 1'b0, 0, 0, 1'b0);
        run_win(2, 3, 1, 1'b1, 0, 0, 1'b0);
        run_win(0, 4, 0, 1'b0, 0, 0, 1'b0);
        run_win(0, 0, 0, 1'b0, 0, 0, 1'b0);
        run_win(1, 1, 1, 1'b0, 0, 0, 1'b1);
        run_win(7, 7, 7, 1'b0, 0, 0, 1'b0);
        run_win(3, 0, 2, 1'b1, 0, 0, 1'b0);
        run_win(127, 0, 0, 1'b0, 0, 0, 1'b0);
        run_win(2, 3, 1, 1'b0, 1, 9, 1'b0);
        run_win(2, 3, 1, 1'b0, 0, 0, 1'b0);
        run_win(2, 3, 1, 1'b0, 2, 9, 1'b0);
        run_win(2, 3, 1, 1'b0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
